// File: rtl/load_store_unit.sv
// Load/store unit in front of a word-addressed, big-endian data memory.
// Handles byte/half/word loads with extension and sub-word stores via read-modify-write.
module load_store_unit #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic        resp_out_of_range,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        RMW_READ,
        WRITE,
        RESP
    } state_t;

    state_t      state, next_state;
    logic [31:0] addr_q, wdata_q, rdata_q, merged_q;
    logic [1:0]  size_q;
    logic        write_q, unsigned_q, mis_q, oor_q;

    logic        accept, req_mis, req_oor;
    logic        size_is_byte, size_is_word;
    logic [4:0]  lane_shift;
    logic [31:0] lane_word, lane_mask, load_value, merged_word;

    assign accept = req_valid && (state == IDLE);

    // Misalignment and range are judged on the live request, then frozen at acceptance.
    assign req_mis = ((req_size == 2'b01) && req_address[0]) ||
                     (req_size[1] && (req_address[1:0] != 2'b00));
    assign req_oor = (req_address >= 32'(MEM_BYTES));

    assign size_is_byte = (size_q == 2'b00);
    assign size_is_word = size_q[1];

    // Big-endian lanes: lowest byte offset lives in the most significant bits.
    always_comb begin
        lane_shift = 5'd0;
        lane_mask  = 32'hFFFF_FFFF;
        if (size_is_byte) begin
            lane_shift = {~addr_q[1:0], 3'b000};
            lane_mask  = 32'h0000_00FF << lane_shift;
        end else if (!size_is_word) begin
            lane_shift = {~addr_q[1], 4'b0000};
            lane_mask  = 32'h0000_FFFF << lane_shift;
        end
    end

    assign lane_word   = mem_read_data >> lane_shift;
    assign merged_word = (mem_read_data & ~lane_mask) | ((wdata_q << lane_shift) & lane_mask);

    always_comb begin
        load_value = mem_read_data;
        if (size_is_byte) begin
            load_value = unsigned_q ? {24'h0, lane_word[7:0]}
                                    : {{24{lane_word[7]}}, lane_word[7:0]};
        end else if (!size_is_word) begin
            load_value = unsigned_q ? {16'h0, lane_word[15:0]}
                                    : {{16{lane_word[15]}}, lane_word[15:0]};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            rdata_q    <= 32'h0;
            merged_q   <= 32'h0;
            size_q     <= 2'b00;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            mis_q      <= 1'b0;
            oor_q      <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                addr_q     <= req_address;
                wdata_q    <= req_wdata;
                size_q     <= req_size;
                write_q    <= req_write;
                unsigned_q <= req_unsigned;
                mis_q      <= req_mis;
                oor_q      <= req_oor;
                rdata_q    <= 32'h0;
            end
            if (state == READ) begin
                rdata_q <= load_value;
            end
            if (state == RMW_READ) begin
                merged_q <= merged_word;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_mis || req_oor) begin
                        next_state = RESP;
                    end else if (!req_write) begin
                        next_state = READ;
                    end else if (req_size[1]) begin
                        next_state = WRITE;
                    end else begin
                        next_state = RMW_READ;
                    end
                end
            end
            READ:     next_state = RESP;
            RMW_READ: next_state = WRITE;
            WRITE:    next_state = RESP;
            RESP:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // The memory bus is driven only during the access states; everything else idles at zero.
    always_comb begin
        req_ready         = (state == IDLE);
        resp_valid        = 1'b0;
        resp_rdata        = 32'h0;
        resp_misaligned   = 1'b0;
        resp_out_of_range = 1'b0;
        mem_address       = 32'h0;
        mem_write_data    = 32'h0;
        mem_read          = 1'b0;
        mem_write         = 1'b0;
        case (state)
            READ, RMW_READ: begin
                mem_read    = 1'b1;
                mem_address = {addr_q[31:2], 2'b00};
            end
            WRITE: begin
                mem_write      = 1'b1;
                mem_address    = {addr_q[31:2], 2'b00};
                mem_write_data = size_is_word ? wdata_q : merged_q;
            end
            RESP: begin
                resp_valid        = 1'b1;
                resp_rdata        = write_q ? 32'h0 : rdata_q;
                resp_misaligned   = mis_q;
                resp_out_of_range = oor_q;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly upstream of the word-addressed, big-endian data memory. Turns MEM-stage load/store requests into word-aligned memory accesses.
- Supports byte, halfword and word accesses. Loads are sign- or zero-extended. Sub-word stores use read-modify-write, because the memory only writes whole words.
- Flags misaligned and out-of-range requests and never issues a memory access for them.
- Uses a valid/ready handshake so the pipeline can stall while an access is in progress.

Parameters:
- MEM_BYTES, 1024: size of the data memory in bytes. Any address >= MEM_BYTES is out of range.

Ports:
- clock  in  1  system clock; all state changes on its rising edge
- reset_n  in  1  asynchronous reset, active-low
- req_valid  in  1  request present
- req_ready  out  1  unit idle; a request is accepted when req_valid & req_ready at a rising edge
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_address  in  32  byte address
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load result; 0 for stores and errors
- resp_misaligned  out  1  valid with resp_valid
- resp_out_of_range  out  1  valid with resp_valid
- mem_address  out  32  word-aligned address, {addr[31:2], 2'b00}
- mem_write_data  out  32  full word to write
- mem_read  out  1  memory read enable (the memory read is combinational)
- mem_write  out  1  memory write enable (the memory writes on the rising edge)
- mem_read_data  in  32  word returned by the memory

Behaviour:
- Reset values: req_ready=1. All other outputs are 0. State is IDLE.
- States: IDLE, READ, RMW_READ, WRITE, RESP.
- Acceptance: a request is accepted only in IDLE. On acceptance, address, size, write, unsigned and wdata are captured into registers.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
- Out of range: addr >= MEM_BYTES. Misalignment is checked first; both flags may be 1 together.
- Transitions out of IDLE on an accepted request:
  - error (either flag) -> RESP
  - load -> READ
  - word store -> WRITE
  - byte or half store -> RMW_READ
- READ: mem_read=1. The extracted and extended value is registered into resp_rdata at the end of the cycle. -> RESP.
- RMW_READ: mem_read=1. The merged word (mem_read_data with the target lane replaced by wdata) is registered. -> WRITE.
- WRITE: mem_write=1. mem_write_data is the merged word, or wdata for a word store. -> RESP.
- RESP: resp_valid=1 for exactly one cycle, with flags and rdata valid. -> IDLE.
- req_ready is 1 only in IDLE. A new request can be accepted in the cycle after RESP.
- Latency, counting cycles after the acceptance edge: error = 1, load = 2, word store = 2, sub-word store = 3.
- Byte lanes are big-endian:
  - Byte offset k uses bits [31-8k : 24-8k].
  - Half offset 0 uses [31:16]; half offset 2 uses [15:0].
- mem_read and mem_write are never 1 in the same cycle.
- Outside READ, RMW_READ and WRITE, mem_address, mem_write_data and the enables are all 0.
- Stores return resp_rdata=0.
- req_* inputs are ignored outside IDLE; only the registered copies are used.
- Reset asserted mid-operation (async):
  - Immediately returns to IDLE with the reset output values.
  - The pending request is discarded and no response is produced.
  - If reset falls before the WRITE edge, no memory write occurs.

Test Plan:
- Preload word 0x10 = 0x801234F6:
  - LB 0x13 -> resp_rdata 0xFFFFFFF6 at acceptance+2.
  - LBU 0x13 -> 0x000000F6.
  - LB 0x10 -> 0xFFFFFF80.
- Same word:
  - LH 0x10 -> 0xFFFF8012.
  - LHU 0x12 -> 0x000034F6.
  - LW 0x10 -> 0x801234F6.
  - Each pulses mem_read for exactly one cycle with mem_address 0x10.
- SB 0x11, wdata 0x000000AB:
  - mem_read at +1, then mem_write at +2 with mem_write_data 0x80AB34F6, resp at +3.
  - A following LW 0x10 -> 0x80AB34F6.
  - Repeat with SH 0x12, wdata 0xBEEF -> word becomes 0x80ABBEEF.
- Error cases (all respond at +1 with resp_rdata 0 and zero memory-enable activity):
  - LW 0x0E -> resp_misaligned=1.
  - LH 0x401 with MEM_BYTES=1024 -> both flags 1.
  - SW 0x400 -> resp_out_of_range=1.
- Hold req_valid=1 with back-to-back loads -> req_ready is high only in IDLE, giving one load accepted every 3 cycles. Check the result order matches the request order.
- SH 0x10 with reset_n driven low during RMW_READ:
  - All outputs go to their reset values within the same cycle; no mem_write and no resp_valid.
  - After release, LW 0x10 returns the unchanged word.
